// File: rtl/lsu_dmem_ctrl.sv
// lsu_dmem_ctrl: one-request-at-a-time load/store unit in front of byte-banked dmem.
// Aligns store data, splits misaligned accesses into two word beats, extends loads.
module lsu_dmem_ctrl #(
   parameter int DMEM_ADDR_WIDTH = 14,
   parameter bit MISALIGN_SPLIT  = 1'b1
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_req_valid,
   output logic                       o_req_ready,
   input  logic                       i_req_write,
   input  logic [31:0]                i_req_addr,
   input  logic [2:0]                 i_req_funct3,
   input  logic [31:0]                i_req_wdata,
   output logic                       o_rsp_valid,
   output logic [31:0]                o_rsp_rdata,
   output logic                       o_rsp_err,
   output logic [DMEM_ADDR_WIDTH-1:0] o_dmem_addr,
   output logic                       o_dmem_read,
   output logic                       o_dmem_write,
   output logic [3:0]                 o_dmem_size,
   output logic [31:0]                o_dmem_din,
   input  logic [31:0]                i_dmem_dout
);

   localparam int WW = DMEM_ADDR_WIDTH - 2;
   localparam logic [WW-1:0] W_ONE = {{(WW-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDLE, BEAT0, CAP0, BEAT1, CAP1, RESP
   } state_t;

   state_t        r_state;
   state_t        w_state_nx;
   logic          r_write;
   logic [2:0]    r_f3;
   logic [1:0]    r_off;
   logic [WW-1:0] r_word;
   logic [7:0]    r_mask;
   logic [63:0]   r_data;
   logic          r_split;
   logic [31:0]   r_buf0;
   logic [31:0]   r_rsp_rdata;
   logic          r_rsp_err;

   logic          w_accept;
   logic          w_bad_f3;
   logic          w_bad_addr;
   logic          w_misal;
   logic          w_err;
   logic [1:0]    w_off;
   logic [7:0]    w_base;
   logic [7:0]    w_mask;
   logic [63:0]   w_data;
   logic [31:0]   w_lo;
   logic [63:0]   w_cat;
   logic [31:0]   w_sh;
   logic [31:0]   w_ext;
   logic          w_rsp_ld;
   logic [31:0]   w_rsp_rdata;
   logic          w_rsp_err;
   logic          w_beat0;
   logic          w_beat1;
   logic          w_beat;
   logic [WW-1:0] w_word_out;

   assign o_req_ready = (r_state == IDLE) & ~i_rst;
   assign w_accept    = i_req_valid & o_req_ready;

   // Request decode, evaluated on the raw request in IDLE
   assign w_off      = i_req_addr[1:0];
   assign w_bad_f3   = (i_req_funct3 == 3'd3)
                     | (i_req_funct3[2:1] == 2'b11)
                     | (i_req_funct3[2] & i_req_write);
   assign w_bad_addr = (i_req_addr >> DMEM_ADDR_WIDTH) != 32'd0;
   assign w_misal    = ((i_req_funct3[1:0] == 2'b01) & (w_off == 2'd3))
                     | ((i_req_funct3[1:0] == 2'b10) & (w_off != 2'd0));
   assign w_err      = w_bad_f3 | w_bad_addr | (w_misal & !MISALIGN_SPLIT);

   always_comb begin
      w_base = 8'h0F;
      case (i_req_funct3[1:0])
         2'b00:   w_base = 8'h01;
         2'b01:   w_base = 8'h03;
         default: w_base = 8'h0F;
      endcase
   end

   assign w_mask = w_base << w_off;
   assign w_data = {32'd0, i_req_wdata} << {w_off, 3'b000};

   // Second beat's word arrives on the bus directly in CAP1
   assign w_lo  = (r_state == CAP1) ? r_buf0 : i_dmem_dout;
   assign w_cat = {i_dmem_dout, w_lo};
   assign w_sh  = 32'(w_cat >> {r_off, 3'b000});

   always_comb begin
      w_ext = w_sh;
      case (r_f3)
         3'd0:    w_ext = {{24{w_sh[7]}}, w_sh[7:0]};
         3'd1:    w_ext = {{16{w_sh[15]}}, w_sh[15:0]};
         3'd4:    w_ext = {24'd0, w_sh[7:0]};
         3'd5:    w_ext = {16'd0, w_sh[15:0]};
         default: w_ext = w_sh;
      endcase
   end

   always_comb begin
      w_state_nx  = r_state;
      w_rsp_ld    = 1'b0;
      w_rsp_rdata = 32'd0;
      w_rsp_err   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (i_req_valid) begin
               if (w_err) begin
                  w_state_nx = RESP;
                  w_rsp_ld   = 1'b1;
                  w_rsp_err  = 1'b1;
               end else begin
                  w_state_nx = BEAT0;
               end
            end
         end
         BEAT0: begin
            if (!r_write) begin
               w_state_nx = CAP0;
            end else if (r_split) begin
               w_state_nx = BEAT1;
            end else begin
               w_state_nx = RESP;
               w_rsp_ld   = 1'b1;
            end
         end
         CAP0: begin
            if (r_split) begin
               w_state_nx = BEAT1;
            end else begin
               w_state_nx  = RESP;
               w_rsp_ld    = 1'b1;
               w_rsp_rdata = w_ext;
            end
         end
         BEAT1: begin
            if (!r_write) begin
               w_state_nx = CAP1;
            end else begin
               w_state_nx = RESP;
               w_rsp_ld   = 1'b1;
            end
         end
         CAP1: begin
            w_state_nx  = RESP;
            w_rsp_ld    = 1'b1;
            w_rsp_rdata = w_ext;
         end
         RESP:    w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_write     <= 1'b0;
         r_f3        <= 3'd0;
         r_off       <= 2'd0;
         r_word      <= '0;
         r_mask      <= 8'd0;
         r_data      <= 64'd0;
         r_split     <= 1'b0;
         r_buf0      <= 32'd0;
         r_rsp_rdata <= 32'd0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         if (w_accept) begin
            r_write <= i_req_write;
            r_f3    <= i_req_funct3;
            r_off   <= w_off;
            r_word  <= i_req_addr[DMEM_ADDR_WIDTH-1:2];
            r_mask  <= w_mask;
            r_data  <= i_req_write ? w_data : 64'd0;
            r_split <= |w_mask[7:4];
         end
         if (r_state == CAP0) begin
            r_buf0 <= i_dmem_dout;
         end
         if (w_rsp_ld) begin
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= w_rsp_err;
         end
      end
   end

   assign w_beat0    = (r_state == BEAT0) & ~i_rst;
   assign w_beat1    = (r_state == BEAT1) & ~i_rst;
   assign w_beat     = w_beat0 | w_beat1;
   assign w_word_out = w_beat1 ? (r_word + W_ONE) : r_word;

   assign o_dmem_read  = w_beat & ~r_write;
   assign o_dmem_write = w_beat & r_write;
   assign o_dmem_addr  = w_beat ? {w_word_out, 2'b00} : '0;
   assign o_dmem_size  = w_beat0 ? r_mask[3:0]
                       : w_beat1 ? r_mask[7:4] : 4'd0;
   assign o_dmem_din   = w_beat0 ? r_data[31:0]
                       : w_beat1 ? r_data[63:32] : 32'd0;

   assign o_rsp_valid = (r_state == RESP) & ~i_rst;
   assign o_rsp_rdata = i_rst ? 32'd0 : r_rsp_rdata;
   assign o_rsp_err   = r_rsp_err & ~i_rst;

endmodule
